// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer in front of the radix-4 long divider.
// It accepts one RV32M DIV/DIVU/REM/REMU op and strobes the divider with
// d_init, then ITERS e_advance cycles, then one e_last cycle.
// It applies the RISC-V divide-by-zero and signed-overflow results, then
// registers the final result with a one-cycle done pulse.
// Optional feature macro: DIV_FAST_SPECIAL_EN. When it is defined, special
// cases jump from IDLE straight to DONE, so the result is ready one cycle
// after the request.
module div_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int ITERS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_req,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_rs1,
    input  logic [XLEN-1:0] div_rs2,
    input  logic            div_flush,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result,
    output logic            d_init,
    output logic            e_advance,
    output logic            e_last,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    output logic            unsign,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] remd
);

    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_LAST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [1:0]      op_r;
    logic [XLEN-1:0] rs1_r;
    logic            div0_r;
    logic            ovf_r;
    logic            busy_r;
    logic            done_r;
    logic            adv_r;
    logic            last_r;
    logic [XLEN-1:0] result_r;

    logic            accept_s;
    logic            div0_s;
    logic            ovf_s;

    // Final value: the special cases win over the divider outputs, and op[1]
    // picks the remainder instead of the quotient.
    function automatic logic [XLEN-1:0] select_result(
        input logic [1:0]      op,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic            div0,
        input logic            ovf,
        input logic [XLEN-1:0] a
    );
        logic [XLEN-1:0] res;
        if (div0) begin
            res = op[1] ? a : {XLEN{1'b1}};
        end else if (ovf) begin
            res = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            res = op[1] ? r : q;
        end
        return res;
    endfunction

    // Decide whether to accept the request and classify the special cases.
    // Overflow applies only to the signed ops (op[0]=0).
    always_comb begin
        accept_s = ~rst & (state_r == S_IDLE) & div_req & ~div_flush;
        div0_s   = (div_rs2 == {XLEN{1'b0}});
        ovf_s    = ~div_op[0]
                 & (div_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                 & (div_rs2 == {XLEN{1'b1}});
    end

    // Main sequencer FSM. It also registers busy, the divider strobes, done
    // and the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CW{1'b0}};
            op_r     <= 2'b00;
            rs1_r    <= {XLEN{1'b0}};
            div0_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            adv_r    <= 1'b0;
            last_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r   <= div_op;
                        rs1_r  <= div_rs1;
                        div0_r <= div0_s;
                        ovf_r  <= ovf_s;
                        cnt_r  <= {CW{1'b0}};
                        busy_r <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
                        if (div0_s | ovf_s) begin
                            state_r  <= S_DONE;
                            done_r   <= 1'b1;
                            result_r <= select_result(div_op, quot, remd,
                                                      div0_s, ovf_s, div_rs1);
                        end else begin
                            state_r <= S_ITER;
                            adv_r   <= 1'b1;
                        end
`else
                        state_r <= S_ITER;
                        adv_r   <= 1'b1;
`endif
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ITER: begin
                    if (div_flush) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        adv_r   <= 1'b0;
                    end else if (cnt_r == CW'(ITERS - 1)) begin
                        state_r <= S_LAST;
                        adv_r   <= 1'b0;
                        last_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_LAST: begin
                    if (div_flush) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        last_r  <= 1'b0;
                    end else begin
                        state_r  <= S_DONE;
                        last_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= select_result(op_r, quot, remd,
                                                  div0_r, ovf_r, rs1_r);
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    adv_r   <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign div_busy   = busy_r;
    assign div_done   = done_r;
    assign div_result = result_r;
    assign d_init     = accept_s;
    assign e_advance  = adv_r;
    assign e_last     = last_r;
    assign dividend   = accept_s ? div_rs1 : {XLEN{1'b0}};
    assign divisor    = accept_s ? div_rs2 : {XLEN{1'b0}};
    assign unsign     = accept_s ? div_op[0] : op_r[0];

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed, table-driven bench for div_seq_ctrl, plus hand-written flush,
// reset and back-to-back sequences. The divider is stood in for by driving
// quot/remd with the values a real divider would produce for each op.
module tb_div_seq_ctrl;

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST_BUILD = 1'b1;
`else
    localparam bit FAST_BUILD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        div_req;
    logic [1:0]  div_op;
    logic [31:0] div_rs1;
    logic [31:0] div_rs2;
    logic        div_flush;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;
    logic        d_init;
    logic        e_advance;
    logic        e_last;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        unsign;
    logic [31:0] quot;
    logic [31:0] remd;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl #(.XLEN(32), .ITERS(16)) dut (
        .clk(clk), .rst(rst), .div_req(div_req), .div_op(div_op),
        .div_rs1(div_rs1), .div_rs2(div_rs2), .div_flush(div_flush),
        .div_busy(div_busy), .div_done(div_done), .div_result(div_result),
        .d_init(d_init), .e_advance(e_advance), .e_last(e_last),
        .dividend(dividend), .divisor(divisor), .unsign(unsign),
        .quot(quot), .remd(remd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one op starting in the current cycle (cycle 0), which must come just after a negedge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r,
                          input int flush_at, input bit hold,
                          output int done_cyc, output logic [31:0] res,
                          output int n_adv, output int n_last, output int n_ovl,
                          output logic d0, output logic [31:0] dvd0, output logic [31:0] dvs0,
                          output logic busy_done, output logic dinit_done, output logic busy_end);
        int  c;
        bit  stop;
        div_req = 1'b1; div_op = op; div_rs1 = a; div_rs2 = b;
        quot = q; remd = r; div_flush = 1'b0;
        #1;
        d0 = d_init; dvd0 = dividend; dvs0 = divisor;
        n_adv = 0; n_last = 0; n_ovl = 0; done_cyc = -1; res = 32'h0;
        busy_done = 1'b0; dinit_done = 1'b0; busy_end = 1'b1;
        c = 0; stop = 1'b0;
        while (!stop && c < 40) begin
            @(negedge clk);
            c++;
            if (!hold) div_req = 1'b0;
            div_flush = (c == flush_at);
            #1;
            if (e_advance) n_adv++;
            if (e_last) n_last++;
            if ((int'(d_init) + int'(e_advance) + int'(e_last)) > 1) n_ovl++;
            if (div_done && done_cyc < 0) begin
                done_cyc = c; res = div_result; busy_done = div_busy; dinit_done = d_init;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_end = div_busy; stop = 1'b1;
            end
            if (flush_at >= 0 && c == flush_at + 1) begin
                busy_end = div_busy; stop = 1'b1;
            end
        end
        div_flush = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, div_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, div_done}, 32'd0);
        check({tag, "_result"}, div_result, 32'd0);
        check({tag, "_strobes"}, {29'd0, d_init, e_advance, e_last}, 32'd0);
        check({tag, "_operands"}, dividend | divisor, 32'd0);
        check({tag, "_unsign"}, {31'd0, unsign}, 32'd0);
    endtask

    initial begin
        int          dc, na, nl, no;
        logic [31:0] res, dvd0, dvs0, prev_result;
        logic        d0, bd, did, be;
        int          exp_cyc;

        vecs[0] = '{2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[1] = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{2'b01, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 1'b0};
        vecs[3] = '{2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 32'd2, 1'b0};
        vecs[4] = '{2'b00, 32'd5, 32'd0, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{2'b10, 32'd5, 32'd0, 32'hDEADBEEF, 32'h12345678, 32'd5, 1'b1};
        vecs[6] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h0BADF00D, 32'h0000_1111, 32'h80000000, 1'b1};
        vecs[7] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0BADF00D, 32'h0000_1111, 32'd0, 1'b1};
        vecs[8] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd0, 1'b0};
        vecs[9] = '{2'b11, 32'd7, 32'd0, 32'hCAFEF00D, 32'h0000_2222, 32'd7, 1'b1};

        rst = 1'b1; div_req = 1'b0; div_op = 2'b00; div_rs1 = 32'd0; div_rs2 = 32'd0;
        div_flush = 1'b0; quot = 32'd0; remd = 32'd0;
        #1;
        check_zero_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            exp_cyc = (FAST_BUILD && vecs[i].special) ? 1 : 18;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, -1, 1'b0,
                   dc, res, na, nl, no, d0, dvd0, dvs0, bd, did, be);
            check($sformatf("v%0d_d_init", i), {31'd0, d0}, 32'd1);
            check($sformatf("v%0d_dividend", i), dvd0, vecs[i].a);
            check($sformatf("v%0d_divisor", i), dvs0, vecs[i].b);
            check($sformatf("v%0d_done_cycle", i), dc, exp_cyc);
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_advances", i), na, (exp_cyc == 1) ? 0 : 16);
            check($sformatf("v%0d_lasts", i), nl, (exp_cyc == 1) ? 0 : 1);
            check($sformatf("v%0d_overlap", i), no, 0);
            check($sformatf("v%0d_busy_at_done", i), {31'd0, bd}, 32'd1);
            check($sformatf("v%0d_busy_after", i), {31'd0, be}, 32'd0);
        end
        prev_result = vecs[9].exp;

        // Flush together with a request in IDLE: the request is not accepted.
        div_req = 1'b1; div_flush = 1'b1; div_op = 2'b01; div_rs1 = 32'd9; div_rs2 = 32'd3;
        #1;
        check("flush_idle_d_init", {31'd0, d_init}, 32'd0);
        @(negedge clk);
        div_req = 1'b0; div_flush = 1'b0;
        #1;
        check("flush_idle_busy", {31'd0, div_busy}, 32'd0);

        // Flush in cycle 5: no done, idle in cycle 6, result held, next op done at 24.
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 32'd2, 5, 1'b0,
               dc, res, na, nl, no, d0, dvd0, dvs0, bd, did, be);
        check("flush_no_done", dc, -1);
        check("flush_busy_c6", {31'd0, be}, 32'd0);
        check("flush_result_held", div_result, prev_result);
        run_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, -1, 1'b0,
               dc, res, na, nl, no, d0, dvd0, dvs0, bd, did, be);
        check("after_flush_done_cycle", 6 + dc, 24);
        check("after_flush_result", res, 32'd2);

        // Reset in cycle 9 of an op: all outputs drop at once, then a new op works.
        div_req = 1'b1; div_op = 2'b01; div_rs1 = 32'd100; div_rs2 = 32'd7;
        quot = 32'd14; remd = 32'd2;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            div_req = 1'b0;
        end
        #1;
        check("pre_rst_busy", {31'd0, div_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, -1, 1'b0,
               dc, res, na, nl, no, d0, dvd0, dvs0, bd, did, be);
        check("post_rst_done_cycle", dc, 18);
        check("post_rst_result", res, 32'hFFFFFFFD);

        // Back-to-back: a held request is refused in the done cycle and taken on the next.
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 32'd2, -1, 1'b1,
               dc, res, na, nl, no, d0, dvd0, dvs0, bd, did, be);
        check("b2b_first_done", dc, 18);
        check("b2b_d_init_in_done", {31'd0, did}, 32'd0);
        check("b2b_d_init_next", {31'd0, d_init}, 32'd1);
        run_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, -1, 1'b0,
               dc, res, na, nl, no, d0, dvd0, dvs0, bd, did, be);
        check("b2b_second_done", dc, 18);
        check("b2b_second_result", res, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
